// File: rtl/shift_pkg.sv
// Shared definitions for the shift register / shift_collect pair.
// Frame length grows by one parity bit when SHIFT_COLLECT_PARITY_EN is defined.
package shift_pkg;

  localparam int unsigned WIDTH_DEF = 4;

`ifdef SHIFT_COLLECT_PARITY_EN
  localparam int unsigned PARITY_BITS = 1;
`else
  localparam int unsigned PARITY_BITS = 0;
`endif

  localparam int unsigned FRAME_LEN = WIDTH_DEF + PARITY_BITS;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } collect_state_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/shift_collect_cnt.sv
// Frame bit counter: clear realigns to 0 (an increment in the same cycle
// counts as the first bit), terminal count flags the last bit of a frame.
module shift_collect_cnt #(
  parameter int unsigned FRAME = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d, base;

  always_comb begin
    base  = clr_i ? '0 : cnt_q;
    tc_o  = inc_i && (base == CW'(FRAME - 1));
    cnt_d = base;
    if (inc_i) begin
      cnt_d = tc_o ? '0 : base + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/shift_collect.sv
// Rebuilds LSB-first serial words into a one-deep valid/ready output buffer.
// Optional even-parity trailer bit: define SHIFT_COLLECT_PARITY_EN.
module shift_collect
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  input  logic                         frame_start,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             word_out,
  output logic                         word_valid,
  output logic                         overrun,
  output logic [$clog2(WIDTH+1)-1:0]   bit_count,
  output logic                         parity_err
);

  localparam int unsigned CW    = $clog2(WIDTH + 1);
  localparam int unsigned FRAME = WIDTH + PARITY_BITS;

  logic [CW-1:0]    cnt, cur_cnt;
  logic             tc, shift_en, load, xfer;
  logic [WIDTH-1:0] asm_q, asm_d, base_asm, word_new;
  logic [WIDTH-1:0] word_q, word_d;
  logic             ovr_q, ovr_d;
  collect_state_e   col_q, col_d;
  buf_state_e       buf_q, buf_d;

  shift_collect_cnt #(
    .FRAME (FRAME),
    .CW    (CW)
  ) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (frame_start),
    .inc_i   (bit_valid),
    .count_o (cnt),
    .tc_o    (tc)
  );

  // frame_start discards the partial word before this cycle's bit is taken
  always_comb begin
    cur_cnt  = frame_start ? '0 : cnt;
    base_asm = frame_start ? '0 : asm_q;
    shift_en = bit_valid && (cur_cnt != CW'(WIDTH));
    asm_d    = base_asm;
    if (shift_en) begin
      asm_d = {bit_in, base_asm[WIDTH-1:1]};
    end
    if (tc) begin
      asm_d = '0;
    end
`ifdef SHIFT_COLLECT_PARITY_EN
    word_new = base_asm;
`else
    word_new = {bit_in, base_asm[WIDTH-1:1]};
`endif
  end

  always_comb begin
    load   = tc && ((buf_q == EMPTY) || out_ready);
    xfer   = (buf_q == FULL) && out_ready;
    buf_d  = buf_q;
    word_d = word_q;
    ovr_d  = ovr_q;
    if (load) begin
      buf_d  = FULL;
      word_d = word_new;
    end else if (xfer) begin
      buf_d = EMPTY;
    end
    if (tc && (buf_q == FULL) && !out_ready) begin
      ovr_d = 1'b1;
    end
  end

  always_comb begin
    col_d = col_q;
    if (tc) begin
      col_d = IDLE;
    end else if (bit_valid) begin
      col_d = COLLECT;
    end else if (frame_start) begin
      col_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      asm_q  <= '0;
      word_q <= '0;
      ovr_q  <= 1'b0;
      buf_q  <= EMPTY;
      col_q  <= IDLE;
    end else begin
      asm_q  <= asm_d;
      word_q <= word_d;
      ovr_q  <= ovr_d;
      buf_q  <= buf_d;
      col_q  <= col_d;
    end
  end

`ifdef SHIFT_COLLECT_PARITY_EN
  logic perr_q, perr_d;

  // on completion base_asm holds the data bits and bit_in is the parity bit
  always_comb begin
    perr_d = perr_q;
    if (load) begin
      perr_d = (^base_asm) ^ bit_in;
    end else if (xfer) begin
      perr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign word_out   = word_q;
  assign word_valid = (buf_q == FULL);
  assign overrun    = ovr_q;
  assign bit_count  = cnt;

  a_col_matches_cnt: assert property (@(posedge clk) disable iff (reset)
    (col_q == COLLECT) == (cnt != '0));

endmodule
